// File: rtl/llr_conv_pipe.sv
// llr_conv_pipe: two-stage multi-lane LLR converter between two's complement and sign-magnitude, with symmetric saturation (saturation counter enabled by LLR_CONV_SAT_CNT_EN)
module llr_conv_pipe #(
  parameter int LANES = 8,
  parameter int IN_W  = 8,
  parameter int OUT_W = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_mode,
  input  logic [LANES*IN_W-1:0]  i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES*OUT_W-1:0] o_data,
  output logic [LANES-1:0]       o_sat_mask,
  input  logic                   i_sat_cnt_clr,
  output logic [31:0]            o_sat_cnt
);
  localparam logic [IN_W-1:0] MAXM = IN_W'((1 << (OUT_W - 1)) - 1);
  if (IN_W < 2 || OUT_W < 2 || OUT_W > IN_W) begin : g_bad_params
    $error("llr_conv_pipe: requires 2 <= OUT_W <= IN_W");
  end
  logic                   s1_valid, s1_mode, s2_valid, s2_adv;
  logic [LANES-1:0]       s1_sign, a_sign, b_sat;
  logic [LANES*IN_W-1:0]  s1_mag, a_mag;
  logic [LANES*OUT_W-1:0] b_out;
  assign s2_adv  = !s2_valid || i_ready;
  assign o_ready = !s1_valid || s2_adv;
  assign o_valid = s2_valid;
  // per lane: sign/magnitude split ahead of S1, clamp and format ahead of S2
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IN_W-1:0]  x, m;
    logic [OUT_W-2:0] c;
    assign x = i_data[k*IN_W +: IN_W];
    assign a_sign[k] = x[IN_W-1];
    assign a_mag[k*IN_W +: IN_W] = i_mode ? {1'b0, x[IN_W-2:0]} : (x[IN_W-1] ? -x : x);
    assign m = s1_mag[k*IN_W +: IN_W];
    assign b_sat[k] = m > MAXM;
    assign c = b_sat[k] ? MAXM[OUT_W-2:0] : m[OUT_W-2:0];
    assign b_out[k*OUT_W +: OUT_W] = s1_mode ? (s1_sign[k] ? -{1'b0, c} : {1'b0, c}) : {s1_sign[k], c};
  end
  // S1: capture sign, absolute magnitude and mode of an accepted beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_sign  <= '0;
      s1_mag   <= '0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_mode <= i_mode;
        s1_sign <= a_sign;
        s1_mag  <= a_mag;
      end
    end
  end
  // S2: capture the formatted result; holds steady while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid   <= 1'b0;
      o_data     <= '0;
      o_sat_mask <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        o_data     <= b_out;
        o_sat_mask <= b_sat;
      end
    end
  end
`ifdef LLR_CONV_SAT_CNT_EN
  localparam int PCW = $clog2(LANES + 1);
  logic [PCW-1:0] pc;
  logic [32:0]    sum;
  // popcount of the outgoing mask added to the running total, one spare bit to catch overflow
  always_comb begin
    pc = '0;
    for (int k = 0; k < LANES; k++) pc = pc + PCW'(o_sat_mask[k]);
    sum = {1'b0, o_sat_cnt} + 33'(pc);
  end
  // sticky saturating event counter; clear takes priority over a transfer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_sat_cnt <= '0;
    else if (i_sat_cnt_clr) o_sat_cnt <= '0;
    else if (o_valid && i_ready) o_sat_cnt <= sum[32] ? '1 : sum[31:0];
  end
`else
  logic unused_clr;
  assign unused_clr = i_sat_cnt_clr;
  assign o_sat_cnt  = '0;
`endif
endmodule
